req_priority_encoder: RTL and testbench

- Sequential inverse of the team's 2-to-4 enable-gated decoder. Collects one-hot or multi-hot request pulses and emits one binary index per valid/ready transfer.
- Used wherever a request vector must be turned back into an index for a downstream consumer that can apply backpressure.
- Pending requests are held sticky, so no pulse is lost while the consumer stalls.

---
 rtl/req_enc_pkg.sv | 19 +
 rtl/enc_prio_sel.sv | 36 +++
 rtl/req_priority_encoder.sv | 131 +++++++++++++
 tb/tb_req_priority_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared types and helpers for the request priority encoder.
//   state_t           : encoder handshake state (IDLE / PRESENT)
//   REQ_ENC_N_DEFAULT : default number of request lines
//   enc_width()       : code width for a given number of request lines
package req_enc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int REQ_ENC_N_DEFAULT = 4;

  // Width of a binary index over n lines; never narrower than one bit.
  function automatic int enc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enc_prio_sel.sv
// enc_prio_sel: combinational descending priority search with wrap-around.
//   vector : candidate request bits
//   base   : index examined first; search continues base-1, base-2, ... mod N
//   idx    : first set index found (0 when none)
//   any    : at least one bit of vector is set
// N must be a power of two so the W-bit subtraction wraps modulo N.
module enc_prio_sel
  import req_enc_pkg::*;
#(
  parameter int N = REQ_ENC_N_DEFAULT,
  localparam int W = enc_width(N)
) (
  input  logic [N-1:0] vector,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // Walk from the lowest priority to the highest so the last hit wins;
  // offset 0 (the base itself) is therefore the top priority.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = base - W'(i);
      if (vector[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_priority_encoder.sv
// req_priority_encoder: collects sticky request pulses and emits one binary
// index per valid/ready transfer.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   en       : capture enable; req ignored while low
//   req      : request pulses, sampled every rising edge
//   ready    : consumer accepts code this cycle
//   valid    : code is valid
//   code     : index of the granted request
//   pending  : registered sticky request vector
//   overflow : one-cycle pulse when a request lands on an already-pending bit
//   busy     : valid OR any pending request (combinational)
// Build option: define REQ_ENC_ROUND_ROBIN_EN for round-robin selection
// starting below the last granted index; otherwise the highest index wins.
module req_priority_encoder
  import req_enc_pkg::*;
#(
  parameter int N = REQ_ENC_N_DEFAULT,
  localparam int W = enc_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] pending,
  output logic         overflow,
  output logic         busy
);

  function automatic logic [N-1:0] onehot(input logic [W-1:0] c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  state_t       state_p1, state_nxt_p0;
  logic [W-1:0] code_p1, code_nxt_p0;
  logic [N-1:0] pending_p1;
  logic         overflow_p1;

  logic         xfer_p0;
  logic [N-1:0] clr_p0, rem_p0, cap_p0;
  logic         overflow_nxt_p0;
  logic [W-1:0] base_p0, sel_idx_p0;
  logic         sel_any_p0;

  // ---- stage p0: capture, clear and selection ----
  assign xfer_p0 = valid & ready;
  assign clr_p0  = xfer_p0 ? onehot(code_p1) : '0;
  assign rem_p0  = pending_p1 & ~clr_p0;
  assign cap_p0  = en ? req : '0;
  // A bit cleared on this edge may be re-requested without counting as overflow.
  assign overflow_nxt_p0 = |(cap_p0 & rem_p0);

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [W-1:0] last_granted_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_granted_p1 <= '0;
    end else if (xfer_p0) begin
      last_granted_p1 <= code_p1;
    end
  end

  // Power-of-two N: W-bit subtraction wraps 0 -> N-1.
  assign base_p0 = last_granted_p1 - W'(1);
`else
  assign base_p0 = W'(N - 1);
`endif

  // Selection always looks at rem, so requests captured on this edge are
  // presented no earlier than the next cycle.
  enc_prio_sel #(
    .N (N)
  ) u_sel (
    .vector (rem_p0),
    .base   (base_p0),
    .idx    (sel_idx_p0),
    .any    (sel_any_p0)
  );

  always_comb begin
    state_nxt_p0 = state_p1;
    code_nxt_p0  = code_p1;
    case (state_p1)
      IDLE: begin
        if (sel_any_p0) begin
          state_nxt_p0 = PRESENT;
          code_nxt_p0  = sel_idx_p0;
        end
      end
      PRESENT: begin
        if (ready) begin
          if (sel_any_p0) begin
            code_nxt_p0 = sel_idx_p0;
          end else begin
            state_nxt_p0 = IDLE;
          end
        end
      end
      default: state_nxt_p0 = IDLE;
    endcase
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= IDLE;
      code_p1     <= '0;
      pending_p1  <= '0;
      overflow_p1 <= 1'b0;
    end else begin
      state_p1    <= state_nxt_p0;
      code_p1     <= code_nxt_p0;
      pending_p1  <= rem_p0 | cap_p0;
      overflow_p1 <= overflow_nxt_p0;
    end
  end

  assign valid    = (state_p1 == PRESENT);
  assign code     = code_p1;
  assign pending  = pending_p1;
  assign overflow = overflow_p1;
  assign busy     = valid | (|pending_p1);

endmodule

// File: tb/tb_req_priority_encoder.sv
module tb_req_priority_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [W-1:0] code;
  logic [N-1:0] pending;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_priority_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .ready    (ready),
    .valid    (valid),
    .code     (code),
    .pending  (pending),
    .overflow (overflow),
    .busy     (busy)
  );

  // Reference model: sticky request set plus the currently offered index.
  bit           m_valid;
  int           m_code;
  bit [N-1:0]   m_pend;
  bit           m_ovf;
  int           m_last;

  function automatic int pick(input bit [N-1:0] v);
    int start;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    start = (m_last + N - 1) % N;
`else
    start = N - 1;
`endif
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start - k + N) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_code  = 0;
    m_pend  = '0;
    m_ovf   = 1'b0;
    m_last  = 0;
  endfunction

  function automatic void model_edge();
    bit [N-1:0] one, clr, rem, cap;
    bit         accepted;
    int         old_code;
    one      = 1;
    accepted = m_valid && (ready === 1'b1);
    old_code = m_code;
    clr      = accepted ? (one << m_code) : '0;
    rem      = m_pend & ~clr;
    cap      = (en === 1'b1) ? req : '0;
    m_ovf    = (cap & rem) != 0;
    if (!m_valid || (ready === 1'b1)) begin
      if (rem != 0) begin
        m_valid = 1'b1;
        m_code  = pick(rem);
      end else begin
        m_valid = 1'b0;
      end
    end
    if (accepted) m_last = old_code;
    m_pend = rem | cap;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"},    32'(valid),    32'(m_valid));
    check({tag, ".code"},     32'(code),     32'(m_code));
    check({tag, ".pending"},  32'(pending),  32'(m_pend));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".busy"},     32'(busy),     32'(m_valid || (m_pend != 0)));
  endtask

  // Called between edges; pulses the asynchronous reset without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    bit [N-1:0] req;
    bit         rdy;
    bit         v;
    bit [W-1:0] c;
    bit [N-1:0] p;
    bit         o;
  } vec_t;

  vec_t tbl[36];

  initial begin
    int rr_exp[6];

    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    ready = 1'b0;
    model_reset();
    #3;
    check("por.valid",    32'(valid),    32'd0);
    check("por.code",     32'(code),     32'd0);
    check("por.pending",  32'(pending),  32'd0);
    check("por.overflow", 32'(overflow), 32'd0);
    check("por.busy",     32'(busy),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // rst, en, req, ready -> valid, code, pending, overflow (after the edge)
    // single request
    tbl[0]  = '{1, 1, 4'b0100, 1, 0, 2'd0, 4'b0100, 0};
    tbl[1]  = '{0, 1, 4'b0000, 1, 1, 2'd2, 4'b0100, 0};
    tbl[2]  = '{0, 1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0};
    tbl[3]  = '{0, 1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0};
    // priority, back-to-back
    tbl[4]  = '{1, 1, 4'b1011, 1, 0, 2'd0, 4'b1011, 0};
    tbl[5]  = '{0, 1, 4'b0000, 1, 1, 2'd3, 4'b1011, 0};
    tbl[6]  = '{0, 1, 4'b0000, 1, 1, 2'd1, 4'b0011, 0};
    tbl[7]  = '{0, 1, 4'b0000, 1, 1, 2'd0, 4'b0001, 0};
    tbl[8]  = '{0, 1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0};
    // backpressure, higher request arriving during the stall
    tbl[9]  = '{1, 1, 4'b0010, 0, 0, 2'd0, 4'b0010, 0};
    tbl[10] = '{0, 1, 4'b0000, 0, 1, 2'd1, 4'b0010, 0};
    tbl[11] = '{0, 1, 4'b1000, 0, 1, 2'd1, 4'b1010, 0};
    tbl[12] = '{0, 1, 4'b0000, 0, 1, 2'd1, 4'b1010, 0};
    tbl[13] = '{0, 1, 4'b0000, 0, 1, 2'd1, 4'b1010, 0};
    tbl[14] = '{0, 1, 4'b0000, 0, 1, 2'd1, 4'b1010, 0};
    tbl[15] = '{0, 1, 4'b0000, 1, 1, 2'd3, 4'b1000, 0};
    tbl[16] = '{0, 1, 4'b0000, 1, 0, 2'd3, 4'b0000, 0};
    // capture disabled
    tbl[17] = '{1, 0, 4'b1111, 1, 0, 2'd0, 4'b0000, 0};
    tbl[18] = '{0, 0, 4'b1111, 1, 0, 2'd0, 4'b0000, 0};
    // overflow on a stalled pending bit, single code emitted
    tbl[19] = '{1, 1, 4'b0100, 0, 0, 2'd0, 4'b0100, 0};
    tbl[20] = '{0, 1, 4'b0000, 0, 1, 2'd2, 4'b0100, 0};
    tbl[21] = '{0, 1, 4'b0100, 0, 1, 2'd2, 4'b0100, 1};
    tbl[22] = '{0, 1, 4'b0000, 0, 1, 2'd2, 4'b0100, 0};
    tbl[23] = '{0, 1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0};
    tbl[24] = '{0, 1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0};
    // same-edge clear and re-request of the same bit
    tbl[25] = '{1, 1, 4'b0001, 1, 0, 2'd0, 4'b0001, 0};
    tbl[26] = '{0, 1, 4'b0000, 1, 1, 2'd0, 4'b0001, 0};
    tbl[27] = '{0, 1, 4'b0001, 1, 0, 2'd0, 4'b0001, 0};
    tbl[28] = '{0, 1, 4'b0000, 1, 1, 2'd0, 4'b0001, 0};
    tbl[29] = '{0, 1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0};
    // all-ones into an empty encoder
    tbl[30] = '{1, 1, 4'b1111, 1, 0, 2'd0, 4'b1111, 0};
    tbl[31] = '{0, 1, 4'b0000, 1, 1, 2'd3, 4'b1111, 0};
    tbl[32] = '{0, 1, 4'b0000, 1, 1, 2'd2, 4'b0111, 0};
    tbl[33] = '{0, 1, 4'b0000, 1, 1, 2'd1, 4'b0011, 0};
    tbl[34] = '{0, 1, 4'b0000, 1, 1, 2'd0, 4'b0001, 0};
    tbl[35] = '{0, 1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0};

    for (int i = 0; i < 36; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].rst) do_reset();
      en    = tbl[i].en;
      req   = tbl[i].req;
      ready = tbl[i].rdy;
      tick();
      check({tag, ".valid"},    32'(valid),    32'(tbl[i].v));
      check({tag, ".code"},     32'(code),     32'(tbl[i].c));
      check({tag, ".pending"},  32'(pending),  32'(tbl[i].p));
      check({tag, ".overflow"}, 32'(overflow), 32'(tbl[i].o));
      check({tag, ".busy"},     32'(busy),     32'(tbl[i].v || (tbl[i].p != 0)));
    end

    // Asynchronous reset mid-stream while valid, pending and overflow are set.
    do_reset();
    en = 1'b1; req = 4'b1010; ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    check("arst.pre_valid", 32'(valid), 32'd1);
    check("arst.pre_code",  32'(code),  32'd3);
    req = 4'b1010;
    tick();
    check("arst.pre_pending",  32'(pending),  32'(4'b1010));
    check("arst.pre_overflow", 32'(overflow), 32'd1);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",    32'(valid),    32'd0);
    check("arst.code",     32'(code),     32'd0);
    check("arst.pending",  32'(pending),  32'd0);
    check("arst.overflow", 32'(overflow), 32'd0);
    check("arst.busy",     32'(busy),     32'd0);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("arst.hold_valid", 32'(valid), 32'd0);

    // All-ones re-asserted every cycle with ready high. The just-granted bit
    // re-arrives on the same edge and is excluded, so fixed priority
    // alternates between the top two indices.
`ifdef REQ_ENC_ROUND_ROBIN_EN
    rr_exp = '{3, 2, 1, 0, 3, 2};
`else
    rr_exp = '{3, 2, 3, 2, 3, 2};
`endif
    do_reset();
    en = 1'b1; req = 4'b1111; ready = 1'b1;
    tick();
    check("rr.first_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr%0d.valid", i), 32'(valid), 32'd1);
      check($sformatf("rr%0d.code", i),  32'(code),  32'(rr_exp[i]));
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      en    = ($urandom_range(0, 7) != 0);
      req   = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      ready = ($urandom_range(0, 3) != 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
